// File: rtl/bpu_btb_ras_if.sv
// Lookup/update bus between the IFU/EXU side and the branch-prediction unit.
//   master : IFU/EXU side, drives requests, updates and invalidations
//   slave  : BPU side, returns the combinational lookup response
// Signals: req_valid/req_ready/req_pc, resp_hit/resp_valid/resp_idx/resp_target,
//          upd_valid/upd_pc/upd_target/upd_taken/upd_kind/upd_hit/upd_idx/upd_ret_addr,
//          inv_valid.
interface bpu_btb_ras_if #(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned IDX_W     = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_BITS-1:0] req_pc;
    logic                 resp_hit;
    logic                 resp_valid;
    logic [IDX_W-1:0]     resp_idx;
    logic [DATA_BITS-1:0] resp_target;
    logic                 upd_valid;
    logic [ADDR_BITS-1:0] upd_pc;
    logic [DATA_BITS-1:0] upd_target;
    logic                 upd_taken;
    logic [1:0]           upd_kind;
    logic                 upd_hit;
    logic [IDX_W-1:0]     upd_idx;
    logic [DATA_BITS-1:0] upd_ret_addr;
    logic                 inv_valid;

    modport master (
        output req_valid, req_pc,
        output upd_valid, upd_pc, upd_target, upd_taken, upd_kind, upd_hit, upd_idx, upd_ret_addr,
        output inv_valid,
        input  req_ready, resp_hit, resp_valid, resp_idx, resp_target
    );

    modport slave (
        input  req_valid, req_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken, upd_kind, upd_hit, upd_idx, upd_ret_addr,
        input  inv_valid,
        output req_ready, resp_hit, resp_valid, resp_idx, resp_target
    );
endinterface

// File: rtl/bpu_btb_ras.sv
// Branch-prediction unit: fully associative BTB with 2-bit counters plus a
// circular return-address stack fed from the resolved-branch update port.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : bpu_btb_ras_if.slave (zero-latency lookup, update, invalidate)
// Optional feature: define BPU_INV_EN to make inv_valid flush all BTB valid
// bits, the victim pointer and the RAS in one cycle; otherwise inv_valid is ignored.
module bpu_btb_ras #(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ENTRIES   = 8,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned IDX_W     = $clog2(ENTRIES)
) (
    input logic          clk,
    input logic          rstn,
    bpu_btb_ras_if.slave bus
);
    localparam int unsigned RAS_PW = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W  = $clog2(RAS_DEPTH + 1);
    localparam logic [1:0]  KIND_BR   = 2'b00;
    localparam logic [1:0]  KIND_CALL = 2'b10;
    localparam logic [1:0]  KIND_RET  = 2'b11;

    logic [ENTRIES-1:0]   valid_q;
    logic [ADDR_BITS-1:0] tag_q  [ENTRIES];
    logic [DATA_BITS-1:0] tgt_q  [ENTRIES];
    logic [1:0]           ctr_q  [ENTRIES];
    logic [1:0]           kind_q [ENTRIES];
    logic [IDX_W-1:0]     victim_q;
    logic [DATA_BITS-1:0] ras_q  [RAS_DEPTH];
    logic [RAS_PW-1:0]    ras_ptr_q;
    logic [CNT_W-1:0]     ras_cnt_q;

    logic                 inv_fire;
    logic                 look_hit;
    logic [IDX_W-1:0]     look_idx;
    logic [DATA_BITS-1:0] ras_top;
    logic                 cam_hit;
    logic [IDX_W-1:0]     cam_idx;
    logic                 free_any;
    logic [IDX_W-1:0]     free_idx;
    logic                 carried_ok;
    logic                 upd_existing;
    logic [IDX_W-1:0]     upd_sel;
    logic                 may_alloc;
    logic [IDX_W-1:0]     alloc_idx;
    logic [1:0]           ctr_cur;
    logic [1:0]           ctr_nxt;

`ifdef BPU_INV_EN
    assign inv_fire = bus.inv_valid;
`else
    assign inv_fire = 1'b0 & bus.inv_valid;
`endif

    // Lookup CAM; scanning downward lets the lowest matching index win.
    always_comb begin
        look_hit = 1'b0;
        look_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (bus.req_valid && valid_q[i] && (tag_q[i] == bus.req_pc)) begin
                look_hit = 1'b1;
                look_idx = IDX_W'(i);
            end
        end
    end

    assign ras_top         = ras_q[ras_ptr_q - RAS_PW'(1)];
    assign bus.req_ready   = bus.req_valid;
    assign bus.resp_hit    = look_hit;
    assign bus.resp_idx    = look_idx;
    assign bus.resp_valid  = look_hit & ctr_q[look_idx][1];
    assign bus.resp_target = !look_hit ? '0 :
                             ((kind_q[look_idx] == KIND_RET) && (ras_cnt_q != '0)) ? ras_top :
                             tgt_q[look_idx];

    // Update-side CAM and lowest free entry search.
    always_comb begin
        cam_hit  = 1'b0;
        cam_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == bus.upd_pc)) begin
                cam_hit = 1'b1;
                cam_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // The index carried from fetch is trusted only if it still holds this PC.
    assign carried_ok   = bus.upd_hit && valid_q[bus.upd_idx] && (tag_q[bus.upd_idx] == bus.upd_pc);
    assign upd_existing = carried_ok || cam_hit;
    assign upd_sel      = carried_ok ? bus.upd_idx : cam_idx;
    assign may_alloc    = bus.upd_taken || (bus.upd_kind != KIND_BR);
    assign alloc_idx    = free_any ? free_idx : victim_q;

    // Saturating 2-bit counter for branches; non-branches pin strong-taken.
    always_comb begin
        ctr_cur = ctr_q[upd_sel];
        ctr_nxt = 2'b11;
        if (bus.upd_kind == KIND_BR) begin
            if (bus.upd_taken) ctr_nxt = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
            else               ctr_nxt = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
        end
    end

    // BTB and RAS state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q   <= '0;
            victim_q  <= '0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]  <= '0;
                tgt_q[i]  <= '0;
                ctr_q[i]  <= '0;
                kind_q[i] <= '0;
            end
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else if (inv_fire) begin
            valid_q   <= '0;
            victim_q  <= '0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (bus.upd_valid) begin
            if (upd_existing) begin
                kind_q[upd_sel] <= bus.upd_kind;
                ctr_q[upd_sel]  <= ctr_nxt;
                if (bus.upd_taken) tgt_q[upd_sel] <= bus.upd_target;
            end else if (may_alloc) begin
                valid_q[alloc_idx] <= 1'b1;
                tag_q[alloc_idx]   <= bus.upd_pc;
                kind_q[alloc_idx]  <= bus.upd_kind;
                tgt_q[alloc_idx]   <= bus.upd_target;
                ctr_q[alloc_idx]   <= (bus.upd_kind == KIND_BR) ? 2'b10 : 2'b11;
                if (!free_any) victim_q <= victim_q + IDX_W'(1);
            end
            // Push overwrites the oldest slot silently once the stack is full.
            if (bus.upd_kind == KIND_CALL) begin
                ras_q[ras_ptr_q] <= bus.upd_ret_addr;
                ras_ptr_q        <= ras_ptr_q + RAS_PW'(1);
                if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + CNT_W'(1);
            end else if ((bus.upd_kind == KIND_RET) && (ras_cnt_q != '0)) begin
                ras_ptr_q <= ras_ptr_q - RAS_PW'(1);
                ras_cnt_q <= ras_cnt_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_bpu_btb_ras.sv
module tb_bpu_btb_ras;
    localparam int unsigned ADDR_BITS = 32;
    localparam int unsigned DATA_BITS = 32;
    localparam int unsigned ENTRIES   = 8;
    localparam int unsigned RAS_DEPTH = 4;
    localparam int unsigned IDX_W     = 3;
    localparam logic [1:0] BR = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    bpu_btb_ras_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .IDX_W(IDX_W)) bus ();

    bpu_btb_ras #(
        .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
        .ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH), .IDX_W(IDX_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [1:0]  m_kind  [ENTRIES];
    int          m_victim;
    logic [31:0] m_ras[$];   // oldest at front, top at back

`ifdef BPU_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    function automatic int m_find(input logic [31:0] pc);
        for (int i = 0; i < int'(ENTRIES); i++)
            if (m_valid[i] && m_tag[i] == pc) return i;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0; m_kind[i] = 0;
        end
        m_victim = 0;
        m_ras.delete();
    endtask

    task automatic m_step();
        int e;
        if (INV_EN && bus.inv_valid) begin
            for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 0;
            m_victim = 0;
            m_ras.delete();
        end else if (bus.upd_valid) begin
            if (bus.upd_hit && m_valid[bus.upd_idx] && m_tag[bus.upd_idx] == bus.upd_pc) e = int'(bus.upd_idx);
            else e = m_find(bus.upd_pc);
            if (e >= 0) begin
                m_kind[e] = bus.upd_kind;
                if (bus.upd_taken) m_tgt[e] = bus.upd_target;
                if (bus.upd_kind == BR) m_ctr[e] = bus.upd_taken ? ((m_ctr[e] < 3) ? m_ctr[e] + 1 : 3)
                                                                 : ((m_ctr[e] > 0) ? m_ctr[e] - 1 : 0);
                else m_ctr[e] = 3;
            end else if (bus.upd_taken || bus.upd_kind != BR) begin
                e = -1;
                for (int i = 0; i < int'(ENTRIES) && e < 0; i++) if (!m_valid[i]) e = i;
                if (e < 0) begin
                    e = m_victim;
                    m_victim = (m_victim + 1) % int'(ENTRIES);
                end
                m_valid[e] = 1; m_tag[e] = bus.upd_pc; m_kind[e] = bus.upd_kind;
                m_tgt[e] = bus.upd_target; m_ctr[e] = (bus.upd_kind == BR) ? 2 : 3;
            end
            if (bus.upd_kind == CALL) begin
                m_ras.push_back(bus.upd_ret_addr);
                if (m_ras.size() > int'(RAS_DEPTH)) void'(m_ras.pop_front());
            end else if (bus.upd_kind == RET && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m_reset();
        else       m_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle out of reset, outputs against the model.
    always @(negedge clk) begin
        if (rstn) begin
            int          e;
            logic [31:0] et;
            e  = bus.req_valid ? m_find(bus.req_pc) : -1;
            et = 0;
            if (e >= 0) et = (m_kind[e] == RET && m_ras.size() > 0) ? m_ras[$] : m_tgt[e];
            chk("ready",  64'(bus.req_ready),   64'(bus.req_valid));
            chk("hit",    64'(bus.resp_hit),    64'(e >= 0));
            chk("valid",  64'(bus.resp_valid),  64'(e >= 0 && m_ctr[e] >= 2));
            chk("idx",    64'(bus.resp_idx),    64'((e >= 0) ? e : 0));
            chk("target", 64'(bus.resp_target), 64'(et));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        bus.req_valid = 0; bus.req_pc = 0;
        bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_target = 0; bus.upd_taken = 0;
        bus.upd_kind = 0; bus.upd_hit = 0; bus.upd_idx = 0; bus.upd_ret_addr = 0;
        bus.inv_valid = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit taken,
                       input logic [1:0] kind, input bit hit, input int idx,
                       input logic [31:0] ret, input bit inv);
        @(posedge clk); #1;
        drive_idle();
        bus.upd_valid = 1; bus.upd_pc = pc; bus.upd_target = tgt; bus.upd_taken = taken;
        bus.upd_kind = kind; bus.upd_hit = hit; bus.upd_idx = IDX_W'(idx);
        bus.upd_ret_addr = ret; bus.inv_valid = inv;
    endtask

    task automatic look(input logic [31:0] pc);
        @(posedge clk); #1;
        drive_idle();
        bus.req_valid = 1; bus.req_pc = pc;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        drive_idle();
        rstn = 0;
        @(posedge clk); #1;
        rstn = 1;
    endtask

    logic [31:0] ret_exp [5];
    logic [31:0] pool_pc;
    int          dup;
    int          e;

    initial begin
        clk = 0;
        rstn = 0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1 rstn = 1;

        // reset state
        look(32'h100);
        chk("rst_hit", 64'(bus.resp_hit), 64'd0);
        chk("rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_target", 64'(bus.resp_target), 64'd0);

        // taken branch allocates weak-taken, then decays
        upd(32'h100, 32'h200, 1, BR, 0, 0, 0, 0);
        look(32'h100);
        chk("br_hit", 64'(bus.resp_hit), 64'd1);
        chk("br_idx", 64'(bus.resp_idx), 64'd0);
        chk("br_valid", 64'(bus.resp_valid), 64'd1);
        chk("br_target", 64'(bus.resp_target), 64'h200);
        chk("br_ctr_model", 64'(m_ctr[0]), 64'd2);
        upd(32'h100, 32'h0, 0, BR, 1, 0, 0, 0);
        upd(32'h100, 32'h0, 0, BR, 1, 0, 0, 0);
        look(32'h100);
        chk("nt2_hit", 64'(bus.resp_hit), 64'd1);
        chk("nt2_valid", 64'(bus.resp_valid), 64'd0);
        chk("nt2_ctr_model", 64'(m_ctr[0]), 64'd0);
        upd(32'h100, 32'h0, 0, BR, 1, 0, 0, 0);
        look(32'h100);
        chk("nt3_valid", 64'(bus.resp_valid), 64'd0);
        chk("nt3_target_kept", 64'(bus.resp_target), 64'h200);
        chk("nt3_ctr_model", 64'(m_ctr[0]), 64'd0);

        // not-taken miss never allocates
        upd(32'h300, 32'h310, 0, BR, 0, 0, 0, 0);
        look(32'h300);
        chk("nt_noalloc", 64'(bus.resp_hit), 64'd0);

        // fill, replace, in-place update
        reset_dut();
        for (int i = 0; i < 8; i++) upd(32'(i * 4), 32'h1000 + 32'(i * 4), 1, JMP, 0, 0, 0, 0);
        upd(32'h40, 32'h1040, 1, JMP, 0, 0, 0, 0);
        look(32'h40);
        chk("repl_idx", 64'(bus.resp_idx), 64'd0);
        chk("repl_target", 64'(bus.resp_target), 64'h1040);
        look(32'h0);
        chk("repl_evicted", 64'(bus.resp_hit), 64'd0);
        chk("victim_model", 64'(m_victim), 64'd1);
        upd(32'h4, 32'h2004, 1, JMP, 0, 0, 0, 0);
        look(32'h4);
        chk("reuse_idx", 64'(bus.resp_idx), 64'd1);
        chk("reuse_target", 64'(bus.resp_target), 64'h2004);
        dup = 0;
        for (int i = 0; i < int'(ENTRIES); i++) if (m_valid[i] && m_tag[i] == 32'h4) dup++;
        chk("nodup_model", 64'(dup), 64'd1);
        chk("victim_still_model", 64'(m_victim), 64'd1);

        // RAS: overflow keeps newest, rets drain, empty ret is no-op
        reset_dut();
        upd(32'h500, 32'h999, 1, RET, 0, 0, 0, 0);
        look(32'h500);
        chk("ret_empty_target", 64'(bus.resp_target), 64'h999);
        for (int k = 0; k < 5; k++) upd(32'h600, 32'h6F0, 1, CALL, 0, 0, 32'hA0 + 32'(k), 0);
        look(32'h500);
        chk("ras_top", 64'(bus.resp_target), 64'hA4);
        chk("ras_size_model", 64'(m_ras.size()), 64'd4);
        ret_exp = '{32'hA3, 32'hA2, 32'hA1, 32'h999, 32'h999};
        for (int k = 0; k < 5; k++) begin
            upd(32'h500, 32'h999, 1, RET, 1, 0, 0, 0);
            look(32'h500);
            chk($sformatf("ret_pop%0d", k), 64'(bus.resp_target), 64'(ret_exp[k]));
        end
        chk("ras_empty_model", 64'(m_ras.size()), 64'd0);

        // invalidate racing an update
        upd(32'h600, 32'h6F0, 1, CALL, 1, 1, 32'hB0, 0);
        upd(32'h700, 32'h710, 1, JMP, 0, 0, 0, 1);
        look(32'h700);
`ifdef BPU_INV_EN
        chk("inv_drop_upd", 64'(bus.resp_hit), 64'd0);
        look(32'h500);
        chk("inv_miss", 64'(bus.resp_hit), 64'd0);
        chk("inv_ras_model", 64'(m_ras.size()), 64'd0);
`else
        chk("noinv_upd_hit", 64'(bus.resp_hit), 64'd1);
        chk("noinv_upd_target", 64'(bus.resp_target), 64'h710);
        look(32'h500);
        chk("noinv_ras_top", 64'(bus.resp_target), 64'hB0);
`endif

        // randomized traffic; small PC pool forces hits, replacement and RAS churn
        reset_dut();
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            drive_idle();
            bus.req_valid = ($urandom_range(0, 9) != 0);
            bus.req_pc    = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 2) != 0) begin
                pool_pc          = 32'($urandom_range(0, 15)) << 2;
                bus.upd_valid    = 1;
                bus.upd_pc       = pool_pc;
                bus.upd_target   = 32'h8000 + 32'($urandom_range(0, 255));
                bus.upd_taken    = $urandom_range(0, 1) != 0;
                bus.upd_kind     = 2'($urandom_range(0, 3));
                bus.upd_ret_addr = $urandom;
                if ($urandom_range(0, 1) != 0) begin
                    e = m_find(pool_pc);
                    bus.upd_hit = (e >= 0);
                    bus.upd_idx = IDX_W'((e >= 0) ? e : 0);
                end else begin
                    bus.upd_hit = $urandom_range(0, 1) != 0;
                    bus.upd_idx = IDX_W'($urandom_range(0, ENTRIES - 1));
                end
            end
            bus.inv_valid = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
